// File: rtl/din_debounce.sv
// din_debounce: 2-flop synchroniser plus stability-count debouncer with edge pulses.
// Optional DIN_DEBOUNCE_EDGE_CNT_EN adds an 8-bit accepted-edge counter output.
module din_debounce #(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_in,
  output logic       d_out,
  output logic       rise,
  output logic       fall,
`ifdef DIN_DEBOUNCE_EDGE_CNT_EN
  output logic [7:0] edge_cnt,
`endif
  output logic       busy
);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state == ST_PENDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      d_out <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      unique case (state)
        ST_STABLE: begin
          if (sync2 != d_out) begin
            state <= ST_PENDING;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        ST_PENDING: begin
          // A glitch that ends early leaves d_out untouched.
          if (sync2 == d_out) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_STABLE;
            cnt   <= '0;
            d_out <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DIN_DEBOUNCE_EDGE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      edge_cnt <= '0;
    else if (rise | fall)
      edge_cnt <= edge_cnt + 8'd1;
  end
`endif

endmodule
